reg_file_dump_reader: RTL and testbench

//   Debug read-side engine for the MIPS register file. On a start pulse it walks a

---
 rtl/reg_file_dump_reader.sv | 167 ++++++++++++++++
 tb/tb_reg_file_dump_reader.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_dump_reader.sv
// reg_file_dump_reader
//   Debug read-side engine for the register file. A start pulse makes it walk
//   a spare combinational read port over every entry and stream each word out
//   on a valid/ready interface, one beat per register (at most one beat every
//   two cycles). A synchronous abort drops the dump at any point.
//
//   Optional build macro: REG_DUMP_CHECKSUM_EN
//     defined   -> a running XOR of all accepted words is sent as one extra
//                  beat (index DEPTH, out_last=1) after the register beats.
//     undefined -> DEPTH beats, out_last on index DEPTH-1.
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous, active-low reset
//   start      1-cycle dump request, ignored while busy
//   abort      abandon a dump in progress (no done pulse)
//   rd_addr    register-file read address (idx, 0 while idle)
//   rd_data    register-file read data, combinational from rd_addr
//   out_valid  beat available
//   out_ready  sink accepts beat
//   out_data   register word (or checksum)
//   out_index  register index of the beat
//   out_last   final beat of the dump
//   busy       engine not idle
//   done       1-cycle pulse after the final handshake
module reg_file_dump_reader #(
    parameter  int DATA_WIDTH = 32,
    parameter  int DEPTH      = 32,
    localparam int ADDR_W     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    output logic [ADDR_W-1:0]     rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_W:0]       out_index,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);

`ifdef REG_DUMP_CHECKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_READ, S_SEND, S_CSUM, S_DONE} state_t;
    localparam logic [ADDR_W:0] IDX_CSUM = (ADDR_W+1)'(DEPTH);
`else
    typedef enum logic [2:0] {S_IDLE, S_READ, S_SEND, S_DONE} state_t;
`endif

    localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(DEPTH - 1);

    state_t                  state;
    state_t                  state_nxt;
    logic [ADDR_W-1:0]       idx;
    logic [ADDR_W-1:0]       idx_nxt;
    logic                    idx_last;
    logic                    hs;
    logic                    vld_p0;
    logic [DATA_WIDTH-1:0]   data_p0;
    logic [ADDR_W:0]         index_p0;
    logic                    last_p0;
`ifdef REG_DUMP_CHECKSUM_EN
    logic [DATA_WIDTH-1:0]   csum;
`endif

    assign idx_last = (idx == IDX_LAST);
`ifdef REG_DUMP_CHECKSUM_EN
    assign vld_p0   = (state == S_SEND) || (state == S_CSUM);
`else
    assign vld_p0   = (state == S_SEND);
`endif
    assign hs       = vld_p0 & out_ready;

    assign rd_addr   = idx;
    assign out_valid = vld_p0;
    assign out_data  = data_p0;
    assign out_index = index_p0;
    assign out_last  = last_p0;
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        case (state)
            S_IDLE: if (start) state_nxt = S_READ;
            S_READ: state_nxt = S_SEND;
            S_SEND: begin
                if (hs) begin
                    if (idx_last) begin
`ifdef REG_DUMP_CHECKSUM_EN
                        state_nxt = S_CSUM;
`else
                        state_nxt = S_DONE;
`endif
                    end else begin
                        idx_nxt   = idx + ADDR_W'(1);
                        state_nxt = S_READ;
                    end
                end
            end
`ifdef REG_DUMP_CHECKSUM_EN
            S_CSUM: if (hs) state_nxt = S_DONE;
`endif
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        // abort wins over everything, including start in IDLE and a same-cycle handshake
        if (abort) state_nxt = S_IDLE;
        // idx only ever returns to 0 through IDLE, so rd_addr never leaves 0..DEPTH-1
        if (state_nxt == S_IDLE) idx_nxt = '0;
    end

    // stage p0: word sampled from the read port at the READ edge, held through SEND
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_p0  <= '0;
            index_p0 <= '0;
            last_p0  <= 1'b0;
        end else if (!abort) begin
            if (state == S_READ) begin
                data_p0  <= rd_data;
                index_p0 <= {1'b0, idx};
`ifdef REG_DUMP_CHECKSUM_EN
                last_p0  <= 1'b0;
`else
                last_p0  <= idx_last;
`endif
            end
`ifdef REG_DUMP_CHECKSUM_EN
            // last register beat accepted: fold it in directly so the
            // checksum beat is ready the very next cycle
            else if (state == S_SEND && hs && idx_last) begin
                data_p0  <= csum ^ data_p0;
                index_p0 <= IDX_CSUM;
                last_p0  <= 1'b1;
            end
`endif
        end
    end

`ifdef REG_DUMP_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            csum <= '0;
        end else if (abort || (state == S_IDLE && start)) begin
            csum <= '0;
        end else if (state == S_SEND && hs) begin
            csum <= csum ^ data_p0;
        end
    end
`endif

endmodule

// File: tb/tb_reg_file_dump_reader.sv
`timescale 1ns/1ps
module tb_reg_file_dump_reader;
    localparam int DW    = 32;
    localparam int DEPTH = 32;
    localparam int AW    = 5;
`ifdef REG_DUMP_CHECKSUM_EN
    localparam int NBEATS = DEPTH + 1;
`else
    localparam int NBEATS = DEPTH;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          out_ready = 1'b0;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [AW:0]   out_index;
    logic          out_last;
    logic          busy;
    logic          done;

    logic [DW-1:0] regs [0:DEPTH-1];
    assign rd_data = regs[rd_addr];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    reg_file_dump_reader #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_index(out_index), .out_last(out_last), .busy(busy), .done(done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(output bit ok);
        int n = 0;
        while (out_valid !== 1'b1 && n < 6) begin
            tick();
            n++;
        end
        ok = (out_valid === 1'b1);
    endtask

    task automatic fill_seq();
        for (int i = 0; i < DEPTH; i++) regs[i] = 32'h1000_0000 + i;
    endtask

    task automatic test_reset();
        #3 rst = 1'b0;
        #2;
        n_checks++; if (rd_addr !== 5'd0)   $display("FAIL reset_rd_addr: got %0d want 0", rd_addr); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else n_pass++;
        n_checks++; if (out_data !== 32'h0) $display("FAIL reset_out_data: got %h want 0", out_data); else n_pass++;
        n_checks++; if (out_index !== 6'd0) $display("FAIL reset_out_index: got %0d want 0", out_index); else n_pass++;
        n_checks++; if (out_last !== 1'b0)  $display("FAIL reset_out_last: got %b want 0", out_last); else n_pass++;
        n_checks++; if ({busy, done} !== 2'b00) $display("FAIL reset_busy_done: got %b want 00", {busy, done}); else n_pass++;
        start = 1'b1;
        tick();
        tick();
        start = 1'b0;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_start_held: got busy %b want 0", busy); else n_pass++;
        rst = 1'b1;
        tick();
    endtask

    task automatic test_full_dump();
        bit ok;
        logic [DW-1:0] exp_d;
        fill_seq();
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++; if ({busy, out_valid} !== 2'b10) $display("FAIL full_read_state: got busy,valid=%b want 10", {busy, out_valid}); else n_pass++;
        tick();
        n_checks++; if (out_valid !== 1'b1) $display("FAIL full_latency: got valid %b want 1 two cycles after start", out_valid); else n_pass++;
        for (int b = 0; b < NBEATS; b++) begin
            wait_valid(ok);
            exp_d = (b < DEPTH) ? (32'h1000_0000 + b) : 32'h0000_0000;
            n_checks++; if (!ok) $display("FAIL full_valid_timeout: beat %0d got no valid", b); else n_pass++;
            n_checks++; if (out_index !== b[5:0]) $display("FAIL full_index: got %0d want %0d", out_index, b); else n_pass++;
            n_checks++; if (out_data !== exp_d) $display("FAIL full_data: beat %0d got %h want %h", b, out_data, exp_d); else n_pass++;
            n_checks++; if (out_last !== (b == NBEATS-1)) $display("FAIL full_last: beat %0d got %b want %b", b, out_last, (b == NBEATS-1)); else n_pass++;
            n_checks++; if (rd_addr !== ((b < DEPTH) ? b[4:0] : 5'd31)) $display("FAIL full_rd_addr: beat %0d got %0d", b, rd_addr); else n_pass++;
            tick();
            n_checks++; if (out_valid !== (NBEATS > DEPTH && b == DEPTH-1)) $display("FAIL full_valid_drop: beat %0d got valid %b after handshake", b, out_valid); else n_pass++;
        end
        n_checks++; if ({busy, done} !== 2'b11) $display("FAIL full_done: got busy,done=%b want 11", {busy, done}); else n_pass++;
        tick();
        n_checks++; if ({busy, done} !== 2'b00) $display("FAIL full_idle: got busy,done=%b want 00", {busy, done}); else n_pass++;
        n_checks++; if (rd_addr !== 5'd0) $display("FAIL full_idle_addr: got %0d want 0", rd_addr); else n_pass++;
    endtask

    task automatic test_backpressure();
        bit ok;
        fill_seq();
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int b = 0; b < NBEATS; b++) begin
            wait_valid(ok);
            n_checks++; if (!ok || out_index !== b[5:0]) $display("FAIL bp_index: got %0d want %0d (valid %b)", out_index, b, out_valid); else n_pass++;
            if (b == 7) begin
                out_ready = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    tick();
                    n_checks++;
                    if (out_valid !== 1'b1 || out_data !== 32'h1000_0007 || out_index !== 6'd7)
                        $display("FAIL bp_hold: stall %0d got valid %b data %h index %0d want 1 10000007 7", k, out_valid, out_data, out_index);
                    else n_pass++;
                end
                out_ready = 1'b1;
            end
            tick();
        end
        n_checks++; if (done !== 1'b1) $display("FAIL bp_done: got %b want 1", done); else n_pass++;
        tick();
    endtask

    task automatic test_abort();
        bit ok;
        bit saw_done = 1'b0;
        fill_seq();
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int b = 0; b <= 12; b++) begin
            wait_valid(ok);
            n_checks++; if (!ok || out_index !== b[5:0]) $display("FAIL abort_pre_index: got %0d want %0d", out_index, b); else n_pass++;
            if (b == 12) abort = 1'b1;
            tick();
            abort = 1'b0;
        end
        n_checks++; if ({out_valid, busy, done} !== 3'b000) $display("FAIL abort_idle: got valid,busy,done=%b want 000", {out_valid, busy, done}); else n_pass++;
        n_checks++; if (rd_addr !== 5'd0) $display("FAIL abort_addr: got %0d want 0", rd_addr); else n_pass++;
        for (int k = 0; k < 3; k++) begin
            if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
            tick();
        end
        n_checks++; if (saw_done !== 1'b0) $display("FAIL abort_no_done: got activity %b want 0", saw_done); else n_pass++;
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        n_checks++; if (busy !== 1'b0) $display("FAIL abort_start_same: got busy %b want 0", busy); else n_pass++;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_index !== 6'd0 || out_data !== 32'h1000_0000)
            $display("FAIL abort_restart: got valid %b index %0d data %h want 1 0 10000000", out_valid, out_index, out_data);
        else n_pass++;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_checks++; if (busy !== 1'b0) $display("FAIL abort_second: got busy %b want 0", busy); else n_pass++;
    endtask

    task automatic test_start_while_busy();
        bit ok;
        int beats = 0;
        fill_seq();
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int b = 0; b < NBEATS; b++) begin
            wait_valid(ok);
            n_checks++; if (!ok || out_index !== b[5:0]) $display("FAIL busy_index: got %0d want %0d", out_index, b); else n_pass++;
            if (ok) beats++;
            start = (b == 10);
            tick();
            start = 1'b0;
        end
        n_checks++; if (beats !== NBEATS) $display("FAIL busy_beat_count: got %0d want %0d", beats, NBEATS); else n_pass++;
        n_checks++; if (done !== 1'b1) $display("FAIL busy_done: got %b want 1", done); else n_pass++;
        start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++; if ({busy, out_valid, done} !== 3'b000) $display("FAIL busy_start_in_done: got busy,valid,done=%b want 000", {busy, out_valid, done}); else n_pass++;
        tick();
        tick();
        n_checks++; if ({busy, out_valid} !== 2'b00) $display("FAIL busy_stays_idle: got busy,valid=%b want 00", {busy, out_valid}); else n_pass++;
    endtask

    task automatic test_reset_mid_dump();
        bit ok;
        fill_seq();
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int b = 0; b <= 20; b++) begin
            wait_valid(ok);
            if (b < 20) tick();
        end
        n_checks++; if (out_index !== 6'd20) $display("FAIL rstmid_reach: got index %0d want 20", out_index); else n_pass++;
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, out_last, busy, done} !== 4'b0000 || out_data !== 32'h0 || out_index !== 6'd0 || rd_addr !== 5'd0)
            $display("FAIL rstmid_outputs: got valid %b last %b busy %b done %b data %h index %0d addr %0d want all 0",
                     out_valid, out_last, busy, done, out_data, out_index, rd_addr);
        else n_pass++;
        tick();
        tick();
        rst = 1'b1;
        tick();
        n_checks++; if ({busy, done} !== 2'b00) $display("FAIL rstmid_after: got busy,done=%b want 00", {busy, done}); else n_pass++;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_index !== 6'd0 || out_data !== 32'h1000_0000)
            $display("FAIL rstmid_restart: got valid %b index %0d data %h want 1 0 10000000", out_valid, out_index, out_data);
        else n_pass++;
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic test_checksum();
        bit ok;
        logic [DW-1:0] exp_sum;
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < DEPTH; i++) regs[i] = i;
            if (pass == 1) regs[5] = 32'hFFFF_FFFF;
`ifdef REG_DUMP_CHECKSUM_EN
            exp_sum = (pass == 1) ? 32'hFFFF_FFFA : 32'h0000_0000;
`else
            exp_sum = (pass == 1) ? 32'hFFFF_FFFF : 32'h0000_0005;
`endif
            out_ready = 1'b1;
            start = 1'b1;
            tick();
            start = 1'b0;
            for (int b = 0; b < NBEATS; b++) begin
                wait_valid(ok);
                if (b == 5) begin
                    n_checks++; if (out_data !== exp_sum && NBEATS == DEPTH) $display("FAIL csum_reg5: got %h want %h", out_data, exp_sum); else n_pass++;
                end
                if (b == DEPTH-1) begin
                    n_checks++; if (out_last !== (NBEATS == DEPTH)) $display("FAIL csum_last_reg31: got %b want %b", out_last, (NBEATS == DEPTH)); else n_pass++;
                end
                if (b == DEPTH) begin
                    n_checks++;
                    if (out_index !== 6'd32 || out_data !== exp_sum || out_last !== 1'b1)
                        $display("FAIL csum_beat: got index %0d data %h last %b want 32 %h 1", out_index, out_data, out_last, exp_sum);
                    else n_pass++;
                end
                tick();
            end
            n_checks++; if (done !== 1'b1 || out_valid !== 1'b0) $display("FAIL csum_done: got done %b valid %b want 1 0", done, out_valid); else n_pass++;
            tick();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) regs[i] = '0;
        test_reset();
        test_full_dump();
        test_backpressure();
        test_abort();
        test_start_while_busy();
        test_reset_mid_dump();
        test_checksum();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
